// File: rtl/coin_acceptor.sv
// Coin acceptor front end. Synchronizes and debounces the two raw coin
// sensors and emits a one-cycle coin code per qualified coin. A coin that
// stays in the slot too long, or both sensors active together, is a jam.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | slot empty, waiting for a sensor to go high
// QUAL     | sensor high, counting consecutive samples to qualify the press
// WAIT_REL | coin accepted, waiting for both sensors to stay low
// JAM      | double sensor or stuck coin; wait for a clean low run
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_MAX        = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sense5,
   input  logic       sense10,
   output logic [1:0] coin,
   output logic       jam,
   output logic [7:0] coin_cnt
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] QUAL     = 2'd1;
   localparam logic [1:0] WAIT_REL = 2'd2;
   localparam logic [1:0] JAM      = 2'd3;

   // Channel encoding doubles as the coin code, so {s10, s5} maps directly.
   localparam logic [1:0] CH_NONE  = 2'b00;
   localparam logic [1:0] CH_5     = 2'b01;
   localparam logic [1:0] CH_BOTH  = 2'b11;

   localparam logic [15:0] DEB16  = 16'(DEBOUNCE_CYCLES);
   localparam logic [15:0] HOLD16 = 16'(HOLD_MAX);
   localparam logic [7:0]  DEB8   = 8'(DEBOUNCE_CYCLES);

   logic [1:0]  sync5, sync10;
   logic        s5, s10;
   logic [1:0]  state, state_nx;
   logic [1:0]  ch, ch_nx;
   logic [15:0] cnt, cnt_nx;
   logic [7:0]  lowcnt, lowcnt_nx;
   logic        accept;
   logic        line, none, both;

   // Two-flop synchronizers for the asynchronous sensor inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync5  <= 2'b00;
         sync10 <= 2'b00;
      end else begin
         sync5  <= {sync5[0], sense5};
         sync10 <= {sync10[0], sense10};
      end
   end

   assign s5   = sync5[1];
   assign s10  = sync10[1];
   assign none = !s5 && !s10;
   assign both = s5 && s10;
   assign line = (ch == CH_5) ? s5 : s10;

   // Next-state logic; cnt is the debounce/hold counter, lowcnt the release run.
   always_comb begin
      state_nx  = state;
      ch_nx     = ch;
      cnt_nx    = cnt;
      lowcnt_nx = lowcnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (!none) begin
               state_nx = QUAL;
               ch_nx    = {s10, s5};
               cnt_nx   = 16'd1;
            end
         end
         QUAL: begin
            if (ch == CH_BOTH) begin
               if (both) begin
                  if (cnt + 16'd1 == DEB16) begin
                     state_nx  = JAM;
                     ch_nx     = CH_NONE;
                     cnt_nx    = 16'd0;
                     lowcnt_nx = 8'd0;
                  end else begin
                     cnt_nx = cnt + 16'd1;
                  end
               end else if (none) begin
                  state_nx = IDLE;
                  ch_nx    = CH_NONE;
                  cnt_nx   = 16'd0;
               end else begin
                  ch_nx  = {s10, s5};
                  cnt_nx = 16'd1;
               end
            end else begin
               if (both) begin
                  ch_nx  = CH_BOTH;
                  cnt_nx = 16'd1;
               end else if (!line) begin
                  // Too short to be a coin: drop it silently.
                  state_nx = IDLE;
                  ch_nx    = CH_NONE;
                  cnt_nx   = 16'd0;
               end else if (cnt + 16'd1 == DEB16) begin
                  state_nx  = WAIT_REL;
                  cnt_nx    = 16'd0;
                  lowcnt_nx = 8'd0;
                  accept    = 1'b1;
               end else begin
                  cnt_nx = cnt + 16'd1;
               end
            end
         end
         WAIT_REL: begin
            if (none) begin
               if (lowcnt + 8'd1 == DEB8) begin
                  state_nx  = IDLE;
                  ch_nx     = CH_NONE;
                  cnt_nx    = 16'd0;
                  lowcnt_nx = 8'd0;
               end else begin
                  lowcnt_nx = lowcnt + 8'd1;
               end
            end else begin
               lowcnt_nx = 8'd0;
               if (line) begin
                  if (cnt + 16'd1 == HOLD16) begin
                     state_nx = JAM;
                     ch_nx    = CH_NONE;
                     cnt_nx   = 16'd0;
                  end else begin
                     cnt_nx = cnt + 16'd1;
                  end
               end
            end
         end
         JAM: begin
            if (none) begin
               if (lowcnt + 8'd1 == DEB8) begin
                  state_nx  = IDLE;
                  lowcnt_nx = 8'd0;
               end else begin
                  lowcnt_nx = lowcnt + 8'd1;
               end
            end else begin
               lowcnt_nx = 8'd0;
            end
         end
         default: begin
            state_nx  = IDLE;
            ch_nx     = CH_NONE;
            cnt_nx    = 16'd0;
            lowcnt_nx = 8'd0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ch       <= CH_NONE;
         cnt      <= 16'd0;
         lowcnt   <= 8'd0;
         coin     <= 2'b00;
         jam      <= 1'b0;
         coin_cnt <= 8'd0;
      end else begin
         state    <= state_nx;
         ch       <= ch_nx;
         cnt      <= cnt_nx;
         lowcnt   <= lowcnt_nx;
         coin     <= accept ? ch : 2'b00;
         jam      <= (state_nx == JAM);
         coin_cnt <= coin_cnt + {7'd0, accept};
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEBOUNCE_CYCLES=4, HOLD_MAX=64, 10 ns clock).
// Edge k below is the k-th rising edge after the raw sensor is driven high;
// the FSM sees the raw value two edges later, so a clean press accepts at edge 6.
module tb_coin_acceptor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sense5 = 1'b0;
   logic       sense10 = 1'b0;
   logic [1:0] coin;
   logic       jam;
   logic [7:0] coin_cnt;

   int total = 0;
   int bad   = 0;
   int pulses, elevens, b2b;
   logic [1:0] prev;

   coin_acceptor #(.DEBOUNCE_CYCLES(4), .HOLD_MAX(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .sense5   (sense5),
      .sense10  (sense10),
      .coin     (coin),
      .jam      (jam),
      .coin_cnt (coin_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_coin", 16'(coin), 16'd0);
      chk("rst_jam", 16'(jam), 16'd0);
      chk("rst_cnt", 16'(coin_cnt), 16'd0);
      chk("rst_state", 16'(dut.state), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) step();
      chk("post_rst_coin", 16'(coin), 16'd0);

      // Clean 5-unit press, 12 cycles high
      sense5 = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 12) sense5 = 1'b0;
         if (coin != 2'b00) pulses++;
         if (k == 5) chk("p5_e5", 16'(coin), 16'd0);
         if (k == 6) chk("p5_e6", 16'(coin), 16'd1);
         if (k == 7) chk("p5_e7", 16'(coin), 16'd0);
         if (k == 7) chk("p5_cnt", 16'(coin_cnt), 16'd1);
         if (jam) chk("p5_jam", 16'(jam), 16'd0);
      end
      chk("p5_pulses", 16'(pulses), 16'd1);
      chk("p5_idle", 16'(dut.state), 16'd0);

      // 2-cycle glitch on sense10
      sense10 = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 2) sense10 = 1'b0;
         if (coin != 2'b00) pulses++;
      end
      chk("gl_pulses", 16'(pulses), 16'd0);
      chk("gl_cnt", 16'(coin_cnt), 16'd1);
      chk("gl_idle", 16'(dut.state), 16'd0);

      // Both sensors high for 10 cycles -> jam
      sense5 = 1'b1;
      sense10 = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 10) begin
            sense5 = 1'b0;
            sense10 = 1'b0;
         end
         if (coin != 2'b00) pulses++;
         if (k == 5)  chk("bj_e5", 16'(jam), 16'd0);
         if (k == 6)  chk("bj_e6", 16'(jam), 16'd1);
         if (k == 15) chk("bj_e15", 16'(jam), 16'd1);
         if (k == 16) chk("bj_e16", 16'(jam), 16'd0);
      end
      chk("bj_pulses", 16'(pulses), 16'd0);
      chk("bj_cnt", 16'(coin_cnt), 16'd1);

      // sense10 stuck high for 80 cycles -> one coin then jam
      sense10 = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 95; k++) begin
         step();
         if (k == 80) sense10 = 1'b0;
         if (coin != 2'b00) pulses++;
         if (k == 6)  chk("st_e6", 16'(coin), 16'd2);
         if (k == 7)  chk("st_e7", 16'(coin), 16'd0);
         if (k == 69) chk("st_e69", 16'(jam), 16'd0);
         if (k == 70) chk("st_e70", 16'(jam), 16'd1);
         if (k == 85) chk("st_e85", 16'(jam), 16'd1);
         if (k == 86) chk("st_e86", 16'(jam), 16'd0);
      end
      chk("st_pulses", 16'(pulses), 16'd1);
      chk("st_cnt", 16'(coin_cnt), 16'd2);

      // Reset then 256 clean presses -> coin_cnt wraps to 0
      #1;
      rst = 1'b0;
      #1;
      chk("rst2_cnt", 16'(coin_cnt), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      pulses = 0;
      elevens = 0;
      b2b = 0;
      prev = 2'b00;
      for (int p = 0; p < 256; p++) begin
         sense5 = 1'b1;
         for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 6) sense5 = 1'b0;
            if (coin != 2'b00) pulses++;
            if (coin == 2'b11) elevens++;
            if (coin != 2'b00 && prev != 2'b00) b2b++;
            prev = coin;
         end
         if (p == 254) chk("wr_255", 16'(coin_cnt), 16'd255);
      end
      chk("wr_pulses", 16'(pulses), 16'd256);
      chk("wr_elevens", 16'(elevens), 16'd0);
      chk("wr_b2b", 16'(b2b), 16'd0);
      chk("wr_cnt", 16'(coin_cnt), 16'd0);

      // Reset two cycles into QUAL with sense5 held high
      sense5 = 1'b1;
      repeat (4) step();
      rst = 1'b0;
      #1;
      chk("mr_coin", 16'(coin), 16'd0);
      chk("mr_jam", 16'(jam), 16'd0);
      pulses = 0;
      repeat (2) begin
         step();
         if (coin != 2'b00) pulses++;
      end
      chk("mr_in_rst", 16'(pulses), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 5) chk("mr_r5", 16'(coin), 16'd0);
         if (k == 6) chk("mr_r6", 16'(coin), 16'd1);
         if (k == 7) chk("mr_r7", 16'(coin), 16'd0);
      end
      chk("mr_cnt", 16'(coin_cnt), 16'd1);
      sense5 = 1'b0;
      repeat (10) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4; consecutive synchronized samples needed to qualify a press or release (range 2..255).
REQ-002 Parameter: HOLD_MAX, default 64; maximum cycles a sensor may stay high after acceptance before jam is declared (range DEBOUNCE_CYCLES+1..65535).
REQ-003 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: sense5  input  1  raw, asynchronous 5-unit coin sensor, high while a coin is in the slot.
REQ-006 Port: sense10  input  1  raw, asynchronous 10-unit coin sensor, high while a coin is in the slot.
REQ-007 Port: coin  output  2  registered coin code for the vending FSM: 00 none, 01 five, 10 ten; 11 never driven.
REQ-008 Port: jam  output  1  registered; high while in the JAM state.
REQ-009 Port: coin_cnt  output  8  registered count of accepted coins.

Function
REQ-010 Each sense line SHALL pass through its own two-flop synchronizer; the FSM uses only the synchronized values s5 and s10.
REQ-011 FSM states SHALL be IDLE, QUAL, WAIT_REL and JAM, with one shared counter (cnt, 16 bit) and a channel register (ch).
REQ-012 IDLE: exactly one of s5/s10 high -> QUAL, ch set to that channel, cnt=1; both high -> QUAL, ch=BOTH, cnt=1; neither -> stay.
REQ-013 QUAL, ch=BOTH: both high -> cnt++; reaching DEBOUNCE_CYCLES -> JAM. One line drops -> ch becomes the remaining line, cnt=1. Both drop -> IDLE.
REQ-014 QUAL, single channel: the other line rising -> ch=BOTH, cnt=1. The channel line low -> IDLE, no coin (glitch rejection). Otherwise cnt++; on reaching DEBOUNCE_CYCLES -> WAIT_REL, cnt=0, and the accept pulse fires.
REQ-015 Accept pulse: coin SHALL equal 01 (ch=5) or 10 (ch=10) for exactly one cycle, starting on the edge that enters WAIT_REL; coin SHALL be 00 at all other times.
REQ-016 Latency: with a clean press, coin SHALL assert on the (DEBOUNCE_CYCLES+2)th rising edge after, and counting, the first edge that samples the raw line high.
REQ-017 WAIT_REL: both lines low for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any high sample resets the low-run; cnt counts cycles the accepted line stays high, and reaching HOLD_MAX -> JAM.
REQ-018 WAIT_REL SHALL ignore the other channel for acceptance; no second coin is emitted until IDLE is re-entered.
REQ-019 JAM: jam=1, no coin emitted; both lines low for DEBOUNCE_CYCLES consecutive cycles -> IDLE, jam drops on that edge.
REQ-020 coin_cnt SHALL increment by 1 on each accept pulse and wrap 255 -> 0 without flag.
REQ-021 Consecutive accepted coins SHALL be separated by at least DEBOUNCE_CYCLES (release) + DEBOUNCE_CYCLES (qualify) cycles; the downstream FSM therefore never sees back-to-back nonzero codes.

Reset
REQ-022 rst low SHALL asynchronously force state=IDLE, cnt=0, ch=none, synchronizer flops=0, coin=00, jam=0, coin_cnt=0.
REQ-023 Reset asserted mid-QUAL or mid-WAIT_REL SHALL discard the partial coin; after release, a line still held high SHALL be treated as a new press and qualified from cnt=1.
REQ-024 Release of rst SHALL take effect on the first rising edge with rst high; no accept pulse within 2 cycles of release.

Verification (DEBOUNCE_CYCLES=4, HOLD_MAX=64, 10 ns clock)
REQ-025 sense5 high for 12 cycles, then low -> coin=01 for exactly 1 cycle at edge 6 after rise; coin_cnt 0->1; jam stays 0.
REQ-026 sense10 glitch high for 2 cycles -> coin stays 00, coin_cnt unchanged, FSM back in IDLE.
REQ-027 sense5 and sense10 both high for 10 cycles, then both low for 4 cycles -> jam=1 from edge 6, no coin; jam=0 after the low run completes.
REQ-028 sense10 held high for 80 cycles -> a single coin=10 pulse, then jam=1 once the high count in WAIT_REL reaches 64.
REQ-029 256 clean 5-coin presses -> coin_cnt wraps to 0; every pulse is exactly one cycle, never 11.
REQ-030 rst pulled low 2 cycles into QUAL with sense5 still high, then released -> no coin during reset; coin=01 exactly 6 edges after release; coin_cnt=1.
